// File: rtl/enc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enc_frame_ctrl
// Brief    : Frame sequencer between UART RX, convolutional encoder and UART
//            TX. Collects NBYTES bytes, streams them LSB-first into the
//            encoder, packs the 2-bit outputs into a 2*NBYTES-byte frame and
//            sends it out byte by byte over the transmitter handshake.
// Option   : define AUTO_TX_EN to skip READY and transmit as soon as the
//            frame is packed (tx_go is then ignored).
// Revision : 1.0 - initial release
// ============================================================================
module enc_frame_ctrl #(
   parameter int NBYTES  = 4,
   parameter int ENC_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_ready,
   input  logic [7:0] rx_data,
   input  logic       clear,
   input  logic       tx_go,
   input  logic [2:0] k_sel,
   output logic       enc_bit,
   output logic       enc_valid,
   output logic [2:0] enc_k,
   input  logic [1:0] enc_out,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   localparam int IB_W = 8 * NBYTES;
   localparam int OB_W = 16 * NBYTES;
   localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);
   localparam logic [5:0] LAST_BIT  = 6'(8 * NBYTES - 1);
   localparam logic [3:0] LAST_TX   = 4'(2 * NBYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RX    = 3'd1,
      S_ENC   = 3'd2,
      S_DRAIN = 3'd3,
      S_READY = 3'd4,
      S_TX    = 3'd5
   } state_t;

   // Per-byte transmit handshake phase
   typedef enum logic [1:0] {
      P_WAIT_IDLE = 2'd0,
      P_WAIT_HI   = 2'd1,
      P_WAIT_LO   = 2'd2
   } tx_ph_t;

   state_t            state;
   tx_ph_t            tx_ph;
   logic [IB_W-1:0]   in_buf;
   logic [OB_W-1:0]   out_buf;
   logic [3:0]        byte_cnt;
   logic [5:0]        bit_idx;
   logic [5:0]        cap_idx;
   logic [3:0]        tx_idx;
   logic [1:0]        hi_wait;
   logic [ENC_LAT-1:0] vld_sh;

   logic [IB_W-1:0]   in_next;
   logic [6:0]        byte_sh;
   logic [6:0]        cap_sh;
   logic [5:0]        bit_nxt;
   logic              byte_done;

   assign busy = (state != S_IDLE);

   // Input buffer with the incoming byte merged in at the current byte slot,
   // plus shift amounts / next bit index used by the sequencer.
   always_comb begin
      byte_sh = {byte_cnt, 3'b000};
      cap_sh  = {cap_idx, 1'b0};
      bit_nxt = bit_idx + 6'd1;
      in_next = (in_buf & ~(IB_W'(8'hFF) << byte_sh)) | (IB_W'(rx_data) << byte_sh);
      // A byte is finished when busy falls, or when busy never rose within
      // two cycles of the start pulse (transmitter missed or was instant).
      byte_done = (state == S_TX) && !tx_busy &&
                  ((tx_ph == P_WAIT_LO) || (tx_ph == P_WAIT_HI && hi_wait == 2'd2));
   end

   // Frame sequencer: receive, encode, capture, transmit
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tx_ph      <= P_WAIT_IDLE;
         in_buf     <= '0;
         out_buf    <= '0;
         byte_cnt   <= '0;
         bit_idx    <= '0;
         cap_idx    <= '0;
         tx_idx     <= '0;
         hi_wait    <= '0;
         vld_sh     <= '0;
         enc_bit    <= 1'b0;
         enc_valid  <= 1'b0;
         enc_k      <= 3'd3;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else if (clear) begin
         // Abort: tx_data is left alone so an in-flight byte stays stable
         state      <= S_IDLE;
         tx_ph      <= P_WAIT_IDLE;
         byte_cnt   <= '0;
         bit_idx    <= '0;
         cap_idx    <= '0;
         tx_idx     <= '0;
         hi_wait    <= '0;
         vld_sh     <= '0;
         enc_bit    <= 1'b0;
         enc_valid  <= 1'b0;
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         vld_sh     <= ENC_LAT'({vld_sh, enc_valid});

         if (rx_data_ready && state != S_IDLE && state != S_RX)
            overrun <= 1'b1;

         // Encoder pairs land in order; qualifier is enc_valid delayed ENC_LAT
         if (vld_sh[ENC_LAT-1]) begin
            out_buf <= (out_buf & ~(OB_W'(2'b11) << cap_sh)) | (OB_W'(enc_out) << cap_sh);
            cap_idx <= (cap_idx == LAST_BIT) ? 6'd0 : cap_idx + 6'd1;
         end

         case (state)
            S_IDLE, S_RX: begin
               if (rx_data_ready) begin
                  in_buf <= in_next;
                  if (state == S_IDLE)
                     enc_k <= k_sel;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt  <= '0;
                     bit_idx   <= '0;
                     enc_valid <= 1'b1;
                     enc_bit   <= in_next[0];
                     state     <= S_ENC;
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                     state    <= S_RX;
                  end
               end
            end
            S_ENC: begin
               if (bit_idx == LAST_BIT) begin
                  bit_idx   <= '0;
                  enc_valid <= 1'b0;
                  enc_bit   <= 1'b0;
                  state     <= S_DRAIN;
               end else begin
                  bit_idx <= bit_nxt;
                  enc_bit <= 1'(in_buf >> bit_nxt);
               end
            end
            S_DRAIN: begin
               if (vld_sh[ENC_LAT-1] && cap_idx == LAST_BIT) begin
`ifdef AUTO_TX_EN
                  tx_idx <= '0;
                  tx_ph  <= P_WAIT_IDLE;
                  state  <= S_TX;
`else
                  state  <= S_READY;
`endif
               end
            end
            S_READY: begin
`ifdef AUTO_TX_EN
               state <= S_IDLE;
`else
               if (tx_go) begin
                  tx_idx <= '0;
                  tx_ph  <= P_WAIT_IDLE;
                  state  <= S_TX;
               end
`endif
            end
            S_TX: begin
               if (byte_done) begin
                  tx_ph <= P_WAIT_IDLE;
                  if (tx_idx == LAST_TX) begin
                     tx_idx     <= '0;
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     tx_idx <= tx_idx + 4'd1;
                  end
               end else begin
                  case (tx_ph)
                     P_WAIT_IDLE: begin
                        if (!tx_busy) begin
                           tx_start <= 1'b1;
                           tx_data  <= 8'(out_buf >> {tx_idx, 3'b000});
                           hi_wait  <= '0;
                           tx_ph    <= P_WAIT_HI;
                        end
                     end
                     P_WAIT_HI: begin
                        if (tx_busy)
                           tx_ph <= P_WAIT_LO;
                        else
                           hi_wait <= hi_wait + 2'd1;
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_enc_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_enc_frame_ctrl
// Brief    : Self-checking bench for enc_frame_ctrl with encoder and
//            transmitter stubs and an arithmetic frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_frame_ctrl;

   localparam int NB  = 4;
   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst, rx_data_ready, clear, tx_go;
   logic [7:0] rx_data;
   logic [2:0] k_sel;
   logic       enc_bit, enc_valid, tx_start, tx_busy, busy, frame_done, overrun;
   logic [2:0] enc_k;
   logic [1:0] enc_out;
   logic [7:0] tx_data;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   enc_frame_ctrl #(.NBYTES(NB), .ENC_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
      .clear(clear), .tx_go(tx_go), .k_sel(k_sel), .enc_bit(enc_bit),
      .enc_valid(enc_valid), .enc_k(enc_k), .enc_out(enc_out),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   // Encoder stub: {bit, ~bit} delayed LAT cycles
   logic [LAT-1:0] enc_dly = '0;
   always @(posedge clk) enc_dly <= LAT'({enc_dly, enc_bit});
   assign enc_out = {enc_dly[LAT-1], ~enc_dly[LAT-1]};

   // Transmitter stub: busy for busy_len cycles after each start (0 = never)
   int busy_len = 100;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   // Output monitor
   logic [7:0] tx_q[$];
   logic       enc_q[$];
   int         runs[$];
   int         run_len = 0, n_starts = 0, n_fd = 0, stab_err = 0;
   logic [7:0] last_tx = '0;
   always @(negedge clk) begin
      if (enc_valid) begin
         enc_q.push_back(enc_bit);
         run_len++;
      end else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         last_tx = tx_data;
         n_starts++;
      end else if (tx_busy && tx_data !== last_tx) begin
         stab_err++;
      end
      if (frame_done) n_fd++;
   end

   typedef logic [7:0] in_t  [NB];
   typedef logic [7:0] out_t [2*NB];

   // Reference: input bit i (LSB-first) becomes pair {b,~b} at output pair i
   function automatic logic in_bit(input in_t ib, input int i);
      return ib[i/8][i%8];
   endfunction

   function automatic void model_frame(input in_t ib, output out_t ob);
      for (int j = 0; j < 2*NB; j++) begin
         int v;
         v = 0;
         for (int p = 0; p < 4; p++)
            v += (in_bit(ib, 4*j + p) ? 2 : 1) << (2*p);
         ob[j] = v[7:0];
      end
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      tx_q.delete(); enc_q.delete(); runs.delete();
      n_starts = 0; n_fd = 0; stab_err = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [2:0] k);
      rx_data = b; k_sel = k; rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   task automatic send_frame(input in_t ib, input logic [2:0] k0, input int gaps);
      for (int n = 0; n < NB; n++) begin
         if (n != 0 && gaps != 0) cyc($urandom_range(0, 2));
         send_byte(ib[n], (n == 0) ? k0 : 3'($urandom_range(3, 6)));
      end
   endtask

   task automatic pulse_go();
      tx_go = 1'b1; @(negedge clk); tx_go = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; @(negedge clk); clear = 1'b0;
   endtask

   task automatic wait_fd(input int target);
      int t;
      t = 0;
      while (n_fd < target && t < 4000) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_data_ready = 1'b1; clear = 1'b1; tx_go = 1'b1;
      rx_data = 8'hA5; k_sel = 3'd6;
      cyc(3);
      rx_data_ready = 1'b0; clear = 1'b0; tx_go = 1'b0;
      cyc(1);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (enc_valid !== 1'b0 || enc_bit !== 1'b0) $display("FAIL reset_enc: got %b%b want 00", enc_valid, enc_bit); else n_pass++;
      n_total++; if (enc_k !== 3'd3) $display("FAIL reset_enc_k: got %0d want 3", enc_k); else n_pass++;
      n_total++; if (tx_start !== 1'b0 || tx_data !== 8'h00) $display("FAIL reset_tx: got %b/%h want 0/00", tx_start, tx_data); else n_pass++;
      n_total++; if (frame_done !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", frame_done, overrun); else n_pass++;
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_ignored_inputs();
      clear_mon();
      pulse_go();
      cyc(1);
      n_total++; if (busy !== 1'b0) $display("FAIL go_in_idle_busy: got %b want 0", busy); else n_pass++;
      // byte arriving together with clear is discarded
      rx_data = 8'h33; k_sel = 3'd4; rx_data_ready = 1'b1; clear = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0; clear = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL rx_with_clear_busy: got %b want 0", busy); else n_pass++;
      cyc(10);
      n_total++; if (n_starts !== 0 || enc_k !== 3'd3) $display("FAIL idle_quiet: starts %0d enc_k %0d want 0/3", n_starts, enc_k); else n_pass++;
   endtask

   task automatic test_directed_frame();
      in_t  ib;
      out_t eb;
      logic [7:0] exp_c [8];
      int   mis;
      ib = '{8'h01, 8'h00, 8'h00, 8'hFF};
      exp_c = '{8'h56, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hAA, 8'hAA};
      busy_len = 100;
      clear_mon();
      send_byte(ib[0], 3'd5);
      for (int n = 1; n < NB; n++) send_byte(ib[n], 3'd3);
      n_total++; if (enc_valid !== 1'b1) $display("FAIL enc_start: enc_valid %b want 1 right after last byte", enc_valid); else n_pass++;
      n_total++; if (enc_k !== 3'd5) $display("FAIL k_hold_enc: got %0d want 5", enc_k); else n_pass++;
      cyc(45);
      n_total++; if (runs.size() != 1 || runs[0] != 32) $display("FAIL enc_run: runs %0d first %0d want 1 run of 32", runs.size(), (runs.size() > 0) ? runs[0] : -1); else n_pass++;
      mis = 0;
      for (int i = 0; i < 8*NB; i++)
         if (i >= enc_q.size() || enc_q[i] !== in_bit(ib, i)) mis++;
      n_total++; if (mis != 0) $display("FAIL enc_bits: %0d wrong bits want 0", mis); else n_pass++;
      cyc(200);
      n_total++; if (n_starts != 0 || busy !== 1'b1) $display("FAIL ready_hold: starts %0d busy %b want 0/1", n_starts, busy); else n_pass++;
      pulse_go();
      wait_fd(1);
      cyc(5);
      n_total++; if (n_fd != 1) $display("FAIL directed_frame_done: got %0d want 1", n_fd); else n_pass++;
      n_total++; if (tx_q.size() != 8) $display("FAIL directed_starts: got %0d want 8", tx_q.size()); else n_pass++;
      for (int j = 0; j < 8; j++) begin
         n_total++;
         if (j >= tx_q.size() || tx_q[j] !== exp_c[j])
            $display("FAIL directed_byte%0d: got %h want %h", j, (j < tx_q.size()) ? tx_q[j] : 8'hxx, exp_c[j]);
         else n_pass++;
      end
      model_frame(ib, eb);
      mis = 0;
      for (int j = 0; j < 8; j++) if (eb[j] !== exp_c[j]) mis++;
      n_total++; if (mis != 0) $display("FAIL directed_model: %0d model bytes differ from table", mis); else n_pass++;
      n_total++; if (stab_err != 0) $display("FAIL tx_data_stable: %0d changes while busy want 0", stab_err); else n_pass++;
      n_total++; if (busy !== 1'b0 || enc_k !== 3'd5) $display("FAIL directed_end: busy %b enc_k %0d want 0/5", busy, enc_k); else n_pass++;
   endtask

   task automatic test_overrun();
      in_t  ib;
      out_t eb;
      int   mis;
      for (int n = 0; n < NB; n++) ib[n] = 8'($urandom);
      busy_len = 5;
      clear_mon();
      send_frame(ib, 3'd4, 1);
      cyc(5);
      send_byte(8'($urandom), 3'd6);
      n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
      cyc(45);
      pulse_go();
      wait_fd(1);
      cyc(3);
      model_frame(ib, eb);
      mis = (tx_q.size() == 2*NB) ? 0 : 1;
      for (int j = 0; j < 2*NB && j < tx_q.size(); j++) if (tx_q[j] !== eb[j]) mis++;
      n_total++; if (mis != 0) $display("FAIL overrun_frame: %0d errors, %0d bytes want 0/8", mis, tx_q.size()); else n_pass++;
      n_total++; if (overrun !== 1'b1 || busy !== 1'b0) $display("FAIL overrun_sticky: got %b busy %b want 1/0", overrun, busy); else n_pass++;
      pulse_clear();
      n_total++; if (overrun !== 1'b0 || busy !== 1'b0) $display("FAIL overrun_clear: got %b busy %b want 0/0", overrun, busy); else n_pass++;
   endtask

   task automatic test_clear_mid_enc();
      in_t ib;
      for (int n = 0; n < NB; n++) ib[n] = 8'($urandom);
      clear_mon();
      send_frame(ib, 3'd3, 0);
      cyc(8);
      pulse_clear();
      n_total++; if (enc_valid !== 1'b0 || busy !== 1'b0) $display("FAIL clear_enc: valid %b busy %b want 0/0", enc_valid, busy); else n_pass++;
      cyc(60);
      n_total++; if (runs.size() != 1 || runs[0] >= 32 || n_starts != 0 || busy !== 1'b0)
         $display("FAIL clear_enc_quiet: runs %0d starts %0d busy %b want 1 short run/0/0", runs.size(), n_starts, busy);
      else n_pass++;
   endtask

   task automatic test_clear_mid_tx();
      in_t  ib;
      out_t eb;
      int   t, mis;
      for (int n = 0; n < NB; n++) ib[n] = 8'($urandom);
      busy_len = 20;
      clear_mon();
      send_frame(ib, 3'd6, 1);
      cyc(45);
      pulse_go();
      t = 0;
      while (n_starts < 4 && t < 2000) begin @(negedge clk); t++; end
      n_total++; if (n_starts != 4) $display("FAIL clear_tx_reach: starts %0d want 4", n_starts); else n_pass++;
      pulse_clear();
      n_total++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL clear_tx: busy %b start %b want 0/0", busy, tx_start); else n_pass++;
      cyc(100);
      n_total++; if (n_starts != 4 || n_fd != 0) $display("FAIL clear_tx_quiet: starts %0d done %0d want 4/0", n_starts, n_fd); else n_pass++;
      model_frame(ib, eb);
      mis = 0;
      for (int j = 0; j < 4 && j < tx_q.size(); j++) if (tx_q[j] !== eb[j]) mis++;
      n_total++; if (mis != 0) $display("FAIL clear_tx_partial: %0d wrong bytes want 0", mis); else n_pass++;
      // a fresh frame after the abort
      for (int n = 0; n < NB; n++) ib[n] = 8'($urandom);
      clear_mon();
      send_frame(ib, 3'd5, 1);
      n_total++; if (enc_k !== 3'd5) $display("FAIL new_frame_k: got %0d want 5", enc_k); else n_pass++;
      cyc(45);
      pulse_go();
      wait_fd(1);
      cyc(3);
      model_frame(ib, eb);
      mis = (tx_q.size() == 2*NB) ? 0 : 1;
      for (int j = 0; j < 2*NB && j < tx_q.size(); j++) if (tx_q[j] !== eb[j]) mis++;
      n_total++; if (mis != 0 || n_fd != 1) $display("FAIL new_frame: %0d errors, done %0d want 0/1", mis, n_fd); else n_pass++;
   endtask

   task automatic test_random_frames();
      in_t  ib;
      out_t eb;
      int   mis;
      logic [2:0] k0;
      for (int f = 0; f < 6; f++) begin
         for (int n = 0; n < NB; n++) ib[n] = 8'($urandom);
         k0 = 3'($urandom_range(3, 6));
         case (f)
            0: busy_len = 0;
            1: busy_len = 1;
            2: busy_len = 2;
            default: busy_len = $urandom_range(1, 30);
         endcase
         clear_mon();
         send_frame(ib, k0, 1);
         n_total++; if (enc_k !== k0) $display("FAIL rnd%0d_k: got %0d want %0d", f, enc_k, k0); else n_pass++;
         cyc(45);
         pulse_go();
         wait_fd(1);
         cyc(3);
         model_frame(ib, eb);
         mis = (tx_q.size() == 2*NB) ? 0 : 1;
         for (int j = 0; j < 2*NB && j < tx_q.size(); j++) if (tx_q[j] !== eb[j]) mis++;
         for (int i = 0; i < 8*NB; i++) if (i >= enc_q.size() || enc_q[i] !== in_bit(ib, i)) mis++;
         if (runs.size() != 1 || runs[0] != 8*NB) mis++;
         n_total++;
         if (mis != 0 || n_fd != 1 || stab_err != 0 || overrun !== 1'b0)
            $display("FAIL rnd%0d_frame: errs %0d done %0d stab %0d ovr %b want 0/1/0/0 (busy_len %0d)", f, mis, n_fd, stab_err, overrun, busy_len);
         else n_pass++;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rx_data_ready = 1'b0; clear = 1'b0; tx_go = 1'b0;
      rx_data = 8'h00; k_sel = 3'd3;
      @(negedge clk);
      test_reset();
      test_ignored_inputs();
      test_directed_frame();
      test_overrun();
      test_clear_mid_enc();
      test_clear_mid_tx();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/enc_frame_ctrl.md
Name: enc_frame_ctrl

Overview:
- Frame sequencer between the UART receiver, the convolutional encoder and the UART transmitter.
- Collects NBYTES received bytes and feeds them one bit per cycle, LSB-first, into the encoder.
- Packs each 2-bit encoder output into an output frame, then streams that frame out byte by byte through the transmitter handshake.
- Replaces ad-hoc button-driven sequencing with one deterministic state machine.

Parameters:
- NBYTES, 4, input bytes per frame (1..8); output frame is 2*NBYTES bytes.
- ENC_LAT, 1, cycles from enc_valid/enc_bit to the matching enc_out (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- clear  in  1  one-cycle abort/reset pulse (debounced button).
- tx_go  in  1  one-cycle request to transmit a completed frame.
- k_sel  in  3  constraint-length select (3..6); sampled when the first byte of a frame arrives.
- enc_bit  out  1  bit presented to the encoder.
- enc_valid  out  1  enc_bit valid this cycle.
- enc_k  out  3  registered k_sel for the encoder.
- enc_out  in  2  encoder output pair.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to send; held stable from tx_start until busy falls.
- tx_busy  in  1  transmitter busy.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the last output byte has finished.
- overrun  out  1  sticky; rx_data_ready arrived outside IDLE/RX. Cleared by rst or clear.

Behaviour:
- Reset values: all outputs 0, enc_k=3, state IDLE, all counters 0, frame buffer 0.
- States and transitions:
  - IDLE -> RX on rx_data_ready.
  - RX -> ENC when byte NBYTES is captured.
  - ENC -> DRAIN after 8*NBYTES enc_valid cycles.
  - DRAIN -> READY after the last pair is captured.
  - READY -> TX on tx_go.
  - TX -> IDLE after byte 2*NBYTES completes.
- RX:
  - Byte n (0-based) is stored at in_buf[8n+7:8n].
  - k_sel is captured into enc_k with byte 0.
  - The cycle after the final byte is stored, ENC begins.
- ENC:
  - enc_valid=1 for exactly 8*NBYTES consecutive cycles.
  - enc_bit = in_buf[i] on cycle i, i=0..8*NBYTES-1.
- Capture:
  - A ENC_LAT-deep shift of enc_valid qualifies enc_out.
  - Pair i is written to out_buf[2i+1:2i].
  - DRAIN ends when the capture count reaches 8*NBYTES; ENC+DRAIN takes 8*NBYTES+ENC_LAT cycles.
- TX, for each byte j=0..2*NBYTES-1, LSB byte first:
  - Wait for tx_busy=0, then drive tx_data=out_buf[8j+7:8j] and tx_start=1 for one cycle.
  - Wait for tx_busy=1, then for tx_busy=0.
  - If tx_busy has not risen within 2 cycles of tx_start, treat the byte as sent.
- frame_done pulses in the cycle TX -> IDLE.
- tx_go outside READY is ignored. rx_data_ready outside IDLE/RX is dropped and sets overrun.
- clear in any state, including mid-ENC or mid-TX:
  - Next cycle: IDLE, counters 0, overrun 0, enc_valid 0, tx_start 0.
  - A byte already being sent by the transmitter is not recalled.
- rst and clear in the same cycle: rst result (identical).
- rx_data_ready together with clear: the byte is discarded.
- Counters are sized for NBYTES=8 (bit index 6 bits, output byte index 4 bits). No wrap occurs inside a frame.

Optional Feature:
- AUTO_TX_EN defined: READY is bypassed. DRAIN -> TX directly, and tx_go is ignored.
- AUTO_TX_EN undefined: the frame waits in READY indefinitely for tx_go, and out_buf is held.

Test Plan:
- Bench encoder stub: enc_out = {bit,~bit} delayed ENC_LAT.
- NBYTES=4, ENC_LAT=1; rx bytes 0x01,0x00,0x00,0xFF; tx_go -> 8 tx_data bytes 0x56,0x55,0x55,0x55,0x55,0x55,0xAA,0xAA, then frame_done once.
- ENC timing: after 4th byte, enc_valid high exactly 32 consecutive cycles; enc_bit sequence 1,0,0,0,0,0,0,0 for byte 0x01; READY reached 33 cycles after ENC entry.
- tx_busy held high 100 cycles per byte -> exactly one tx_start per byte, tx_data stable throughout, 8 starts total.
- Fifth rx_data_ready during ENC -> overrun=1, output bytes unchanged; clear -> overrun=0, busy=0 next cycle.
- clear asserted at TX byte 3 -> IDLE, no further tx_start; new 4-byte frame then encodes and transmits correctly.
- k_sel=5 at byte 0, changed to 3 mid-frame -> enc_k stays 5 until the next frame's byte 0.
